// File: rtl/aerout_ack_ctrl.sv
// Four-phase AER output handshake slave with programmable ACK latency, event FIFO and counter.
// Optional handshake timeout is enabled by defining AEROUT_TIMEOUT_EN.
module aerout_ack_ctrl #(
    parameter int unsigned AER_WIDTH   = 12,
    parameter int unsigned DLY_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AER_WIDTH-1:0]          aerout_addr_i,
    input  logic                          aerout_req_i,
    output logic                          aerout_ack_o,
    input  logic [DLY_WIDTH-1:0]          ack_delay_i,
    input  logic                          sample_clr_i,
    output logic                          evt_valid_o,
    output logic [AER_WIDTH-1:0]          evt_addr_o,
    input  logic                          evt_rdy_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [CNT_WIDTH-1:0]          evt_cnt_o,
    output logic                          timeout_err_o
);

    localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlWidth = PtrWidth + 1;
    localparam logic [LvlWidth-1:0] FullLevel = LvlWidth'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StDelay   = 2'd1;
    localparam logic [1:0] StAck     = 2'd2;
    localparam logic [1:0] StWaitLow = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [DLY_WIDTH-1:0] dly_q, dly_d;
    logic                 ack_q, ack_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlWidth-1:0]  level_q, level_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [AER_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic fifo_full, fifo_empty, push, pop;

`ifdef AEROUT_TIMEOUT_EN
    localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYC - 1);

    logic [TmoWidth-1:0] tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                tmo_fire;
`endif

    // Full is taken from the registered level, so a same-cycle pop cannot admit a push.
    assign fifo_full  = (level_q == FullLevel);
    assign fifo_empty = (level_q == '0);
    assign push       = (state_q == StIdle) && aerout_req_i && !fifo_full;
    assign pop        = evt_rdy_i && !fifo_empty;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
`ifdef AEROUT_TIMEOUT_EN
        tmo_fire = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (push) begin
                    dly_d   = ack_delay_i;
                    state_d = (ack_delay_i == '0) ? StAck : StDelay;
                end
            end
            StDelay: begin
                dly_d = dly_q - 1'b1;
                if (dly_q == DLY_WIDTH'(1)) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!aerout_req_i) begin
                    state_d = StIdle;
                end
`ifdef AEROUT_TIMEOUT_EN
                else if (tmo_q == TmoLast) begin
                    state_d  = StWaitLow;
                    tmo_fire = 1'b1;
                end
`endif
            end
            StWaitLow: begin
                if (!aerout_req_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ack_d = (state_d == StAck);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    // A clear coinciding with a capture still counts that capture.
    always_comb begin
        cnt_d = cnt_q;
        if (sample_clr_i) begin
            cnt_d = push ? CNT_WIDTH'(1) : '0;
        end else if (push && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            dly_q    <= '0;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= aerout_addr_i;
        end
    end

`ifdef AEROUT_TIMEOUT_EN
    assign tmo_d = ((state_q == StAck) && (state_d == StAck)) ? tmo_q + 1'b1 : '0;
    assign err_d = tmo_fire | (err_q & ~sample_clr_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign timeout_err_o = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign timeout_err_o  = 1'b0;
`endif

    assign aerout_ack_o = ack_q;
    assign evt_valid_o  = !fifo_empty;
    assign evt_addr_o   = mem_q[rd_ptr_q];
    assign fifo_level_o = level_q;
    assign evt_cnt_o    = cnt_q;

endmodule

// File: tb/tb_aerout_ack_ctrl.sv
// Self-checking bench for aerout_ack_ctrl: directed table, corner sequences, random vs queue model.
// Timeout checks follow AEROUT_TIMEOUT_EN.
module tb_aerout_ack_ctrl;

    localparam int AW   = 12;
    localparam int DW   = 4;
    localparam int FD   = 16;
    localparam int CW   = 4;
    localparam int TC   = 64;
    localparam int LW   = $clog2(FD) + 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [AW-1:0] aer_addr;
    logic          req;
    logic          ack;
    logic [DW-1:0] ack_delay;
    logic          clr;
    logic          valid;
    logic [AW-1:0] evt_addr;
    logic          rdy;
    logic [LW-1:0] level;
    logic [CW-1:0] cnt;
    logic          tmo;

    aerout_ack_ctrl #(
        .AER_WIDTH  (AW),
        .DLY_WIDTH  (DW),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW),
        .TIMEOUT_CYC(TC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .aerout_addr_i(aer_addr),
        .aerout_req_i (req),
        .aerout_ack_o (ack),
        .ack_delay_i  (ack_delay),
        .sample_clr_i (clr),
        .evt_valid_o  (valid),
        .evt_addr_o   (evt_addr),
        .evt_rdy_i    (rdy),
        .fifo_level_o (level),
        .evt_cnt_o    (cnt),
        .timeout_err_o(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int dly;
        int addr;
        int lat;
        int lvl;
        int cnt;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input int dly, input int addr, output int lat);
        ack_delay = DW'(dly);
        aer_addr  = AW'(addr);
        req       = 1'b1;
        lat       = 0;
        do begin
            step();
            lat++;
        end while (!ack && lat < 200);
        step();
        check("ack_hold", 32'(ack), 1);
        req = 1'b0;
        step();
        check("ack_fall", 32'(ack), 0);
    endtask

    // Transaction-level model state for the random phase
    logic [AW-1:0] mq[$];
    int  m_cnt, cap_e, cap_n, pre_size, phase, gap, hold, lat, ack_hi;
    bit  hs_act, ack_exp, cap_m, pop_m;

    initial begin
        tbl[0] = '{dly: 6,  addr: 'h123, lat: 7,  lvl: 1, cnt: 1};
        tbl[1] = '{dly: 0,  addr: 'h045, lat: 1,  lvl: 2, cnt: 2};
        tbl[2] = '{dly: 3,  addr: 'hABC, lat: 4,  lvl: 3, cnt: 3};
        tbl[3] = '{dly: 15, addr: 'hFFF, lat: 16, lvl: 4, cnt: 4};
        tbl[4] = '{dly: 1,  addr: 'h001, lat: 2,  lvl: 5, cnt: 5};

        rst = 1'b1; req = 1'b0; aer_addr = '0; ack_delay = '0; clr = 1'b0; rdy = 1'b0;
        step();
        step();
        check("rst_ack", 32'(ack), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_tmo", 32'(tmo), 0);
        rst = 1'b0;
        step();

        // Table: one handshake per row, consumer stalled
        for (int i = 0; i < 5; i++) begin
            handshake(tbl[i].dly, tbl[i].addr, lat);
            check("tbl_lat", 32'(lat), 32'(tbl[i].lat));
            check("tbl_level", 32'(level), 32'(tbl[i].lvl));
            check("tbl_cnt", 32'(cnt), 32'(tbl[i].cnt));
            check("tbl_head", 32'(evt_addr), 32'(tbl[0].addr));
            check("tbl_valid", 32'(valid), 1);
        end
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_addr", 32'(evt_addr), 32'(tbl[i].addr));
            step();
        end
        rdy = 1'b0;
        check("drain_empty", 32'(valid), 0);

        // REQ held 10 cycles with zero delay: exactly one capture
        ack_delay = '0;
        aer_addr  = 'h321;
        req       = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("hold_ack", 32'(ack), 1);
        end
        check("hold_level", 32'(level), 1);
        req = 1'b0;
        step();
        check("hold_fall", 32'(ack), 0);
        check("hold_cnt", 32'(cnt), 6);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("hold_pop", 32'(level), 0);

        // Fill to full, saturate the counter, then back-pressure the 17th event
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_cnt", 32'(cnt), 0);
        for (int i = 0; i < 16; i++) begin
            handshake(0, i, lat);
            check("fill_lat", 32'(lat), 1);
        end
        check("full_level", 32'(level), 16);
        check("sat_cnt", 32'(cnt), CMAX);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_cnt2", 32'(cnt), 0);
        check("clr_noflush", 32'(level), 16);
        ack_delay = 4'd2;
        aer_addr  = 'h7AA;
        req       = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("full_noack", 32'(ack), 0);
        end
        check("full_stall_level", 32'(level), 16);
        check("full_head", 32'(evt_addr), 0);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("pop_no_cap", 32'(level), 15);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ack && lat < 200);
        check("bp_lat", 32'(lat), 3);
        check("bp_level", 32'(level), 16);
        step();
        req = 1'b0;
        step();
        check("bp_fall", 32'(ack), 0);
        check("bp_cnt", 32'(cnt), 1);
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("bp_drain", 32'(evt_addr), (i < 15) ? 32'(i + 1) : 32'h7AA);
            step();
        end
        rdy = 1'b0;
        check("bp_empty", 32'(level), 0);

        // Clear coincident with a capture counts that capture
        ack_delay = '0;
        aer_addr  = 'h055;
        req       = 1'b1;
        clr       = 1'b1;
        step();
        clr = 1'b0;
        check("clr_cap_cnt", 32'(cnt), 1);
        req = 1'b0;
        step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;

        // Asynchronous reset during DELAY, then during ACK
        ack_delay = 4'd10;
        aer_addr  = 'h3C3;
        req       = 1'b1;
        step();
        step();
        step();
        check("dly_noack", 32'(ack), 0);
        check("dly_level", 32'(level), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_level", 32'(level), 0);
        check("arst_cnt", 32'(cnt), 0);
        check("arst_valid", 32'(valid), 0);
        req = 1'b0;
        #1 rst = 1'b0;
        step();
        handshake(2, 'h0F0, lat);
        check("post_rst_lat", 32'(lat), 3);
        check("post_rst_level", 32'(level), 1);
        check("post_rst_addr", 32'(evt_addr), 'h0F0);
        ack_delay = '0;
        req       = 1'b1;
        step();
        check("ack_pre_rst", 32'(ack), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ack", 32'(ack), 0);
        req = 1'b0;
        #1 rst = 1'b0;
        step();

        // REQ stuck high for 100 cycles
        ack_delay = '0;
        aer_addr  = 'h111;
        req       = 1'b1;
        ack_hi    = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (ack) ack_hi++;
        end
        check("stuck_level", 32'(level), 1);
`ifdef AEROUT_TIMEOUT_EN
        check("tmo_ack_cycles", 32'(ack_hi), TC);
        check("tmo_flag", 32'(tmo), 1);
        check("tmo_ack_low", 32'(ack), 0);
        req = 1'b0;
        step();
        handshake(0, 'h222, lat);
        check("tmo_recap_lat", 32'(lat), 1);
        check("tmo_recap_level", 32'(level), 2);
        check("tmo_sticky", 32'(tmo), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("tmo_clr", 32'(tmo), 0);
`else
        check("stuck_ack_cycles", 32'(ack_hi), 100);
        check("stuck_tmo", 32'(tmo), 0);
        req = 1'b0;
        step();
        check("stuck_fall", 32'(ack), 0);
`endif

        // Random traffic against a queue model
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        mq.delete();
        m_cnt  = 0;
        hs_act = 1'b0;
        phase  = 0;
        gap    = 0;
        hold   = 0;
        cap_e  = 0;
        cap_n  = 0;
        req    = 1'b0;
        for (int e = 0; e < 4000; e++) begin
            rdy       = (e < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 49) == 0);
            ack_delay = ($urandom_range(0, 7) == 0) ? DW'(15) : DW'($urandom_range(0, 3));

            pre_size = mq.size();
            pop_m    = rdy && (pre_size > 0);
            cap_m    = !hs_act && req && (pre_size < FD);
            if (hs_act && !req) hs_act = 1'b0;
            if (cap_m) begin
                hs_act = 1'b1;
                cap_e  = e;
                cap_n  = int'(ack_delay);
            end
            if (pop_m) void'(mq.pop_front());
            if (cap_m) mq.push_back(aer_addr);
            if (clr) m_cnt = cap_m ? 1 : 0;
            else if (cap_m && m_cnt < CMAX) m_cnt++;
            ack_exp = hs_act && (e >= cap_e + cap_n);

            step();
            check("rnd_ack", 32'(ack), 32'(ack_exp));
            check("rnd_valid", 32'(valid), 32'(mq.size() > 0));
            check("rnd_level", 32'(level), 32'(mq.size()));
            check("rnd_cnt", 32'(cnt), 32'(m_cnt));
            check("rnd_tmo", 32'(tmo), 0);
            if (mq.size() > 0) check("rnd_addr", 32'(evt_addr), 32'(mq[0]));

            case (phase)
                0: begin
                    if (gap == 0) begin
                        req      = 1'b1;
                        aer_addr = AW'($urandom_range(0, (1 << AW) - 1));
                        phase    = 1;
                    end else begin
                        gap--;
                    end
                end
                1: begin
                    if (ack_exp) begin
                        hold  = $urandom_range(0, 3);
                        phase = 2;
                    end
                end
                default: begin
                    if (hold == 0) begin
                        req   = 1'b0;
                        gap   = $urandom_range(0, 3);
                        phase = 0;
                    end else begin
                        hold--;
                    end
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aerout_ack_ctrl.md
Name: aerout_ack_ctrl

Overview:
- Parametrised AER output receiver for the SNN core's output spike bus.
- Replaces the fixed 6-stage ACK shift register with a true four-phase handshake slave:
  - runtime-programmable ACK latency;
  - event FIFO buffering of output addresses, with back-pressure;
  - per-sample event counting.
- Sits between the core's AEROUT_* port and downstream readout logic (goodness/classification).

Parameters:
- AER_WIDTH, 12, width of AEROUT_ADDR.
- DLY_WIDTH, 4, width of ACK_DELAY.
- FIFO_DEPTH, 16, event FIFO entries; must be a power of 2, ≥2.
- CNT_WIDTH, 16, event counter width.
- TIMEOUT_CYC, 64, max cycles ACK may stay high waiting for REQ to drop (optional feature only).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- AEROUT_ADDR  in  AER_WIDTH  output event address from core.
- AEROUT_REQ  in  1  event request, same clock domain, no synchroniser.
- AEROUT_ACK  out  1  acknowledge, registered.
- ACK_DELAY  in  DLY_WIDTH  extra ACK latency in cycles.
- SAMPLE_CLR  in  1  one-cycle pulse that clears EVT_CNT and TIMEOUT_ERR.
- EVT_VALID  out  1  FIFO not empty.
- EVT_ADDR  out  AER_WIDTH  FIFO head address (first-word-fall-through).
- EVT_RDY  in  1  consumer pops when EVT_VALID & EVT_RDY.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- EVT_CNT  out  CNT_WIDTH  events captured since last SAMPLE_CLR, saturating.
- TIMEOUT_ERR  out  1  sticky handshake timeout flag.

Behaviour:
- Reset, asynchronous, RST high:
  - state IDLE;
  - AEROUT_ACK=0, EVT_VALID=0, FIFO_LEVEL=0, EVT_CNT=0, TIMEOUT_ERR=0;
  - FIFO pointers zero.
- Reset mid-handshake drops ACK immediately; the pending event is lost if not yet pushed.
- FSM states: IDLE, DELAY, ACK, WAIT_LOW.
- IDLE:
  - ACK=0.
  - On an edge where REQ=1 and FIFO not full (full sampled before any same-cycle pop):
    - push AEROUT_ADDR;
    - EVT_CNT+1;
    - latch ACK_DELAY into the delay counter.
    - If the latched value is 0, go to ACK; else go to DELAY.
  - REQ=1 with FIFO full: stall in IDLE (no capture, no ACK) until a pop frees space; capture occurs on the first edge where the registered full flag is low.
- DELAY: decrement the counter each cycle; when it reaches 0, go to ACK.
- Latency: ACK is high N+1 cycles after the first cycle REQ is seen high (N = latched ACK_DELAY). ACK_DELAY=6 reproduces the legacy 7-cycle latency.
- ACK: AEROUT_ACK=1; hold until REQ is sampled 0, then ACK=0 on the next edge and return to IDLE.
- One capture per REQ assertion. A new capture requires REQ low, then high again.
- WAIT_LOW: used only with the optional feature. ACK=0; return to IDLE when REQ=0.
- ACK_DELAY changes after capture do not affect the in-flight handshake.
- FIFO:
  - circular, pointers wrap modulo FIFO_DEPTH;
  - push and pop may occur in the same cycle (level unchanged);
  - pop when empty is ignored;
  - EVT_ADDR is valid only when EVT_VALID=1.
- EVT_CNT:
  - saturates at 2^CNT_WIDTH−1;
  - SAMPLE_CLR in the same cycle as a capture yields EVT_CNT=1;
  - SAMPLE_CLR does not flush the FIFO.

Optional Feature:
- Macro: AEROUT_TIMEOUT_EN.
- Defined:
  - a counter runs while in ACK;
  - if REQ is still high after TIMEOUT_CYC cycles in ACK, set TIMEOUT_ERR (sticky until SAMPLE_CLR or RST), drop ACK, and go to WAIT_LOW;
  - the event is not recaptured.
- Undefined:
  - ACK holds indefinitely until REQ falls;
  - TIMEOUT_ERR is tied 0;
  - WAIT_LOW is unreachable;
  - the port is still present.

Test Plan:
- ACK_DELAY=6, REQ high with ADDR=0x123, dropped 1 cycle after ACK rises:
  - ACK rises on cycle 7 after REQ, falls 1 cycle after REQ falls;
  - EVT_VALID=1, EVT_ADDR=0x123, EVT_CNT=1.
- ACK_DELAY=0:
  - ACK high 1 cycle after REQ;
  - REQ held high for 10 cycles gives one capture only (FIFO_LEVEL=1).
- EVT_RDY=0, 16 handshakes with ADDR 0..15:
  - FIFO_LEVEL=16;
  - 17th REQ gets no ACK;
  - one pop (EVT_ADDR=0), then the 17th event is captured and ACK follows ACK_DELAY+1 cycles later.
- CNT_WIDTH=4, 20 events with EVT_RDY=1:
  - EVT_CNT=15 (saturated);
  - SAMPLE_CLR → 0;
  - SAMPLE_CLR coincident with a capture → 1.
- RST asserted during DELAY with ACK_DELAY=10:
  - ACK=0, FIFO_LEVEL=0, EVT_CNT=0 immediately;
  - next REQ is handled normally.
- With AEROUT_TIMEOUT_EN, TIMEOUT_CYC=64, REQ held for 100 cycles:
  - ACK drops after 64 cycles in ACK, TIMEOUT_ERR=1;
  - no second capture until REQ low then high;
  - SAMPLE_CLR clears TIMEOUT_ERR.
